// File: rtl/button_debounce.sv
// Cleans a raw active-low push-button: 2-FF sync, counter debounce, press/hold FSM.
// Outputs are all registered; PRESSED is the debounced level, the rest are 1-cycle strobes.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUT,
  output logic PRESSED,
  output logic PRESS,
  output logic RELEASE,
  output logic SHORT,
  output logic LONG
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } state_t;

  logic          s1;
  logic          s2;
  logic          db;
  logic          pressed_q;
  logic [CW-1:0] cnt;
  logic          flip_due;
  logic          acc_press;
  logic          acc_release;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;
  logic          press_nxt;
  logic          release_nxt;
  logic          short_nxt;
  logic          long_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= BUT;
      s2 <= s1;
    end
  end

  // Accept strobes are combinational so the FSM registers its strobes on the same edge as db.
  assign flip_due    = (s2 != db) && (cnt == CNT_LAST);
  assign acc_press   = flip_due && !s2;
  assign acc_release = flip_due && s2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db        <= 1'b1;
      pressed_q <= 1'b0;
      cnt       <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db        <= s2;
      pressed_q <= !s2;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (acc_press) begin
          state_nxt = DOWN;
          press_nxt = 1'b1;
          hcnt_nxt  = HW'(1);
        end
      end
      DOWN: begin
        // Release takes priority over a coincident hold terminal count.
        if (acc_release) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          short_nxt   = 1'b1;
          hcnt_nxt    = '0;
        end else if (hcnt == HCNT_LAST) begin
          state_nxt = HELD;
          long_nxt  = 1'b1;
        end else begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      HELD: begin
        if (acc_release) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          hcnt_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        hcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      hcnt    <= '0;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      SHORT   <= 1'b0;
      LONG    <= 1'b0;
    end else begin
      state   <= state_nxt;
      hcnt    <= hcnt_nxt;
      PRESS   <= press_nxt;
      RELEASE <= release_nxt;
      SHORT   <= short_nxt;
      LONG    <= long_nxt;
    end
  end

  assign PRESSED = pressed_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Expected output events are queued with their cycle number and checked every cycle.
module tb_button_debounce;

  logic CLK;
  logic RST;
  logic BUT;
  logic PRESSED;
  logic PRESS;
  logic RELEASE;
  logic SHORT;
  logic LONG;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .BUT    (BUT),
    .PRESSED(PRESSED),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .SHORT  (SHORT),
    .LONG   (LONG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [4:0] vec;  // {PRESSED, PRESS, RELEASE, SHORT, LONG}
  } ev_t;

  ev_t  sb[$];
  int   total;
  int   bad;
  int   cyc;
  int   c;
  logic exp_level;

  task automatic expect_ev(input int at, input logic [4:0] v);
    ev_t e;
    e.cyc = at;
    e.vec = v;
    sb.push_back(e);
  endtask

  // Advance one clock and compare all outputs at the following negedge.
  task automatic tick(input string tag);
    logic [4:0] obs;
    logic [4:0] expv;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    obs  = {PRESSED, PRESS, RELEASE, SHORT, LONG};
    expv = {exp_level, 4'b0000};
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      expv      = sb[0].vec;
      exp_level = expv[4];
      void'(sb.pop_front());
    end
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_now(input string tag, input logic [4:0] expv);
    logic [4:0] obs;
    obs = {PRESSED, PRESS, RELEASE, SHORT, LONG};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    exp_level = 1'b0;
    RST       = 1'b1;
    BUT       = 1'b0;

    // 1: reset with button held, then press detected after edge 6
    repeat (3) tick("t1_rst_hold");
    RST = 1'b0;
    cyc = 0;
    expect_ev(6, 5'b11000);
    repeat (10) tick("t1_press");
    BUT = 1'b1;
    expect_ev(16, 5'b00110);
    repeat (10) tick("t1_release");

    // 2: bounce pattern 3 low / 1 high never gets accepted
    for (int i = 0; i < 10; i++) begin
      BUT = 1'b0;
      repeat (3) tick("t2_bounce");
      BUT = 1'b1;
      tick("t2_bounce");
    end
    repeat (8) tick("t2_settle");

    // 3: short press
    c   = cyc;
    BUT = 1'b0;
    expect_ev(c + 6, 5'b11000);
    repeat (10) tick("t3_short_down");
    BUT = 1'b1;
    expect_ev(c + 16, 5'b00110);
    repeat (30) tick("t3_short_up");

    // 4: long press, LONG once 20 cycles after PRESS, release without SHORT
    c   = cyc;
    BUT = 1'b0;
    expect_ev(c + 6, 5'b11000);
    expect_ev(c + 26, 5'b10001);
    repeat (40) tick("t4_long_down");
    BUT = 1'b1;
    expect_ev(c + 46, 5'b00100);
    repeat (10) tick("t4_long_up");

    // 5: release accepted on the same edge hold count hits terminal
    c   = cyc;
    BUT = 1'b0;
    expect_ev(c + 6, 5'b11000);
    repeat (20) tick("t5_race_down");
    BUT = 1'b1;
    expect_ev(c + 26, 5'b00110);
    repeat (15) tick("t5_race_up");

    // 6: reset while HELD clears outputs at once; no strobes afterwards
    c   = cyc;
    BUT = 1'b0;
    expect_ev(c + 6, 5'b11000);
    expect_ev(c + 26, 5'b10001);
    repeat (30) tick("t6_held");
    RST = 1'b1;
    BUT = 1'b1;
    #1;
    exp_level = 1'b0;
    check_now("t6_rst_async", 5'b00000);
    repeat (3) tick("t6_rst_hold");
    RST = 1'b0;
    repeat (30) tick("t6_after_rst");

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
